npu_dot_tree_acc: RTL and testbench

//  Parametrised successor of the 8-lane NPU add tree. Computes the N-lane dot product of

---
 rtl/npu_dot_tree_acc_pkg.sv | 74 +++++++
 rtl/npu_dot_tree_acc_booth_pp_lane.sv | 43 ++++
 rtl/npu_dot_tree_acc.sv | 165 ++++++++++++++++
 tb/tb_npu_dot_tree_acc.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/npu_dot_tree_acc_pkg.sv
// Shared types and elaboration helpers for the Booth/CSA dot-product accumulator.
// The CSA helpers describe a 3:2 reduction tree as one flat node array, level by level.
package npu_tree_pkg;

    typedef enum logic [2:0] {
        ZERO = 3'b000,
        P1   = 3'b001,
        P2   = 3'b010,
        M1   = 3'b101,
        M2   = 3'b110
    } booth_digit_e;

    typedef struct packed {
        logic       neg;
        logic [1:0] mag;
    } booth_code_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Exact signed width of one lane product / of the full dot product.
    function automatic int dwpp(input int dwa, input int dwb);
        return dwa + dwb + 2;
    endfunction

    function automatic int dwdot(input int dwa, input int dwb, input int lanes);
        return dwpp(dwa, dwb) + clog2(lanes);
    endfunction

    localparam int DWPP  = dwpp(8, 8);
    localparam int DWDOT = dwdot(8, 8, 8);

    function automatic booth_digit_e booth_enc(input logic [2:0] bits);
        case (bits)
            3'b001, 3'b010: return P1;
            3'b011:         return P2;
            3'b100:         return M2;
            3'b101, 3'b110: return M1;
            default:        return ZERO;
        endcase
    endfunction

    // Row count after lvl 3:2 levels, starting from n rows.
    function automatic int csa_cnt(input int n, input int lvl);
        int c;
        c = n;
        for (int unsigned i = 0; i < unsigned'(lvl); i++) c = 2 * (c / 3) + c % 3;
        return c;
    endfunction

    function automatic int csa_levels(input int n);
        int c;
        int l;
        c = n;
        l = 0;
        while (c > 2) begin
            c = 2 * (c / 3) + c % 3;
            l++;
        end
        return l;
    endfunction

    function automatic int csa_off(input int n, input int lvl);
        int o;
        o = 0;
        for (int unsigned i = 0; i < unsigned'(lvl); i++) o += csa_cnt(n, int'(i));
        return o;
    endfunction

endpackage

// File: rtl/npu_dot_tree_acc_booth_pp_lane.sv
// One MAC lane: radix-4 Booth recoding of the weight into DWB/2+1 partial-product rows.
// Negated rows are one's complemented; their +1 corrections are gathered into o_neg.
module npu_booth_pp_lane
    import npu_tree_pkg::*;
#(
    parameter int DWA = 8,
    parameter int DWB = 8,
    parameter int W   = 21
) (
    input  logic [DWA-1:0]           i_act,
    input  logic [DWB-1:0]           i_wgt,
    input  logic                     i_signed,
    output logic [DWB/2:0][W-1:0]    o_pp,
    output logic [W-1:0]             o_neg
);

    localparam int NDIG = DWB / 2 + 1;

    logic [W-1:0]   w_ax;
    logic [DWB+2:0] w_b;

    // Extra operand bit makes unsigned full-scale values representable as signed.
    assign w_ax = W'($signed({i_signed & i_act[DWA-1], i_act}));
    assign w_b  = {{2{i_signed & i_wgt[DWB-1]}}, i_wgt, 1'b0};

    always_comb begin : p_rows
        booth_code_t  w_code;
        logic [W-1:0] w_mag;
        o_pp  = '0;
        o_neg = '0;
        for (int unsigned j = 0; j < NDIG; j++) begin
            w_code = booth_code_t'(booth_enc(w_b[2*j+2 -: 3]));
            case (w_code.mag)
                2'd1:    w_mag = w_ax;
                2'd2:    w_mag = w_ax << 1;
                default: w_mag = '0;
            endcase
            o_pp[j]      = (w_code.neg ? ~w_mag : w_mag) << (2 * j);
            o_neg[2 * j] = w_code.neg;
        end
    end

endmodule

// File: rtl/npu_dot_tree_acc.sv
// N-lane Booth dot product with a 3:2 CSA tree and a multi-beat signed accumulator.
// Three stages (input reg, PP+compress, CPA+accumulate) share one global stall.
module npu_dot_tree_acc
    import npu_tree_pkg::*;
#(
    parameter int LANES = 8,
    parameter int DWA   = 8,
    parameter int DWB   = 8,
    parameter int DWACC = 32,
    parameter int SAT   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*DWA-1:0]   in_data,
    input  logic [LANES*DWB-1:0]   in_para,
    input  logic                   is_signed,
    input  logic                   acc_first,
    input  logic                   acc_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DWACC-1:0]       out_result,
    output logic                   out_ovf
);

    localparam int WT    = dwdot(DWA, DWB, LANES);
    localparam int NDIG  = DWB / 2 + 1;
    localparam int RPL   = NDIG + 1;
    localparam int NROW  = LANES * RPL;
    localparam int NLVL  = csa_levels(NROW);
    localparam int NNODE = csa_off(NROW, NLVL) + 2;

    logic                 w_adv;
    logic                 r_s1_valid, r_s1_signed, r_s1_first, r_s1_last;
    logic [LANES*DWA-1:0] r_s1_data;
    logic [LANES*DWB-1:0] r_s1_para;
    logic                 r_s2_valid, r_s2_first, r_s2_last;
    logic [WT-1:0]        r_s2_sum, r_s2_carry;
    logic [DWACC-1:0]     r_acc, r_out_result;
    logic                 r_sticky, r_out_valid, r_out_ovf;

    assign w_adv      = ~r_out_valid | out_ready;
    assign in_ready   = w_adv;
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_ovf    = r_out_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_signed <= 1'b0;
            r_s1_first  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_data   <= '0;
            r_s1_para   <= '0;
        end else if (w_adv) begin
            r_s1_valid  <= in_valid;
            r_s1_signed <= is_signed;
            r_s1_first  <= acc_first;
            r_s1_last   <= acc_last;
            r_s1_data   <= in_data;
            r_s1_para   <= in_para;
        end
    end

    logic [LANES-1:0][NDIG-1:0][WT-1:0] w_pp;
    logic [LANES-1:0][WT-1:0]           w_neg;
    logic [WT-1:0]                      w_node [NNODE];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        npu_booth_pp_lane #(.DWA(DWA), .DWB(DWB), .W(WT)) u_lane (
            .i_act    (r_s1_data[l*DWA +: DWA]),
            .i_wgt    (r_s1_para[l*DWB +: DWB]),
            .i_signed (r_s1_signed),
            .o_pp     (w_pp[l]),
            .o_neg    (w_neg[l])
        );
        for (genvar j = 0; j < NDIG; j++) begin : g_row
            assign w_node[l*RPL + j] = w_pp[l][j];
        end
        assign w_node[l*RPL + NDIG] = w_neg[l];
    end

    // Each level packs groups of three rows into sum/carry; leftover rows pass through.
    for (genvar v = 0; v < NLVL; v++) begin : g_lvl
        localparam int C  = csa_cnt(NROW, v);
        localparam int O  = csa_off(NROW, v);
        localparam int ON = csa_off(NROW, v + 1);
        localparam int G  = C / 3;
        for (genvar g = 0; g < G; g++) begin : g_csa
            logic [WT-1:0] w_x, w_y, w_z;
            assign w_x = w_node[O + 3*g];
            assign w_y = w_node[O + 3*g + 1];
            assign w_z = w_node[O + 3*g + 2];
            assign w_node[ON + 2*g]     = w_x ^ w_y ^ w_z;
            assign w_node[ON + 2*g + 1] = {(w_x[WT-2:0] & w_y[WT-2:0]) |
                                           (w_x[WT-2:0] & w_z[WT-2:0]) |
                                           (w_y[WT-2:0] & w_z[WT-2:0]), 1'b0};
        end
        for (genvar r = 0; r < C % 3; r++) begin : g_pass
            assign w_node[ON + 2*G + r] = w_node[O + 3*G + r];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_first <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_sum   <= '0;
            r_s2_carry <= '0;
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
            r_s2_first <= r_s1_first;
            r_s2_last  <= r_s1_last;
            r_s2_sum   <= w_node[NNODE-2];
            r_s2_carry <= w_node[NNODE-1];
        end
    end

    logic [WT-1:0]    w_dot;
    logic [DWACC-1:0] w_dot_acc, w_base, w_res;
    logic [DWACC:0]   w_sum;
    logic             w_ovf, w_sticky;

    assign w_dot     = r_s2_sum + r_s2_carry;
    assign w_dot_acc = DWACC'($signed(w_dot));
    assign w_base    = r_s2_first ? '0 : r_acc;
    assign w_sum     = {w_base[DWACC-1], w_base} + {w_dot_acc[DWACC-1], w_dot_acc};
    assign w_ovf     = w_sum[DWACC] ^ w_sum[DWACC-1];
    assign w_sticky  = (r_s2_first ? 1'b0 : r_sticky) | w_ovf;

    always_comb begin
        w_res = w_sum[DWACC-1:0];
        if (w_ovf && SAT != 0) begin
            w_res = w_sum[DWACC] ? {1'b1, {(DWACC-1){1'b0}}} : {1'b0, {(DWACC-1){1'b1}}};
        end
    end

    // Emitting clears acc, so a following beat without acc_first starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc        <= '0;
            r_sticky     <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_ovf    <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= r_s2_valid & r_s2_last;
            if (r_s2_valid) begin
                if (r_s2_last) begin
                    r_out_result <= w_res;
                    r_out_ovf    <= w_sticky;
                    r_acc        <= '0;
                    r_sticky     <= 1'b0;
                end else begin
                    r_acc    <= w_res;
                    r_sticky <= w_sticky;
                end
            end
        end
    end

endmodule

// File: tb/tb_npu_dot_tree_acc.sv
// Directed bench for npu_dot_tree_acc: a 32-bit instance plus 20-bit saturating and wrapping ones.
module tb_npu_dot_tree_acc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, is_signed, acc_first, acc_last, out_ready;
    logic [63:0] in_data, in_para;

    logic        m_in_ready, m_out_valid, m_out_ovf;
    logic [31:0] m_out_result;
    logic        s_in_ready, s_out_valid, s_out_ovf;
    logic [19:0] s_out_result;
    logic        w_in_ready, w_out_valid, w_out_ovf;
    logic [19:0] w_out_result;

    int n_pass = 0;
    int n_total = 0;
    int hs = 0;

    always #5 clk = ~clk;

    npu_dot_tree_acc #(.LANES(8), .DWA(8), .DWB(8), .DWACC(32), .SAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_data(in_data), .in_para(in_para), .is_signed(is_signed),
        .acc_first(acc_first), .acc_last(acc_last), .out_valid(m_out_valid),
        .out_ready(out_ready), .out_result(m_out_result), .out_ovf(m_out_ovf));

    npu_dot_tree_acc #(.LANES(8), .DWA(8), .DWB(8), .DWACC(20), .SAT(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_para(in_para), .is_signed(is_signed),
        .acc_first(acc_first), .acc_last(acc_last), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_result(s_out_result), .out_ovf(s_out_ovf));

    npu_dot_tree_acc #(.LANES(8), .DWA(8), .DWB(8), .DWACC(20), .SAT(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_data(in_data), .in_para(in_para), .is_signed(is_signed),
        .acc_first(acc_first), .acc_last(acc_last), .out_valid(w_out_valid),
        .out_ready(out_ready), .out_result(w_out_result), .out_ovf(w_out_ovf));

    always @(posedge clk) if (m_out_valid && out_ready) hs++;

    typedef struct {
        logic [63:0] data;
        logic [63:0] para;
        logic        sg;
        longint      exp;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic send(input logic [63:0] d, input logic [63:0] p,
                        input logic sg, input logic f, input logic l);
        int n;
        n = 0;
        in_data = d; in_para = p; is_signed = sg; acc_first = f; acc_last = l;
        in_valid = 1'b1;
        while (!m_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!m_in_ready) begin
            n_total++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic get(input string name, output longint rm, output longint rs, output longint rw,
                       output logic om, output logic os, output logic ow, output int lat);
        lat = 0;
        while (!m_out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!m_out_valid) begin
            n_total++;
            $display("FAIL %s_timeout: out_valid stayed 0 for %0d cycles", name, lat);
        end
        rm = $signed(m_out_result);
        rs = $signed(s_out_result);
        rw = $signed(w_out_result);
        om = m_out_ovf; os = s_out_ovf; ow = w_out_ovf;
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        longint rm, rs, rw;
        logic   om, os, ow;
        int     lat, hs0;

        vecs[0]  = '{64'h8080808080808080, 64'h8080808080808080, 1'b1, 131072};
        vecs[1]  = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 520200};
        vecs[2]  = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b1, 8};
        vecs[3]  = '{64'h0706050403020100, 64'h0101010101010101, 1'b1, 28};
        vecs[4]  = '{64'h7F7F7F7F7F7F7F7F, 64'h8080808080808080, 1'b1, -130048};
        vecs[5]  = '{64'h8080808080808080, 64'h7F7F7F7F7F7F7F7F, 1'b0, 130048};
        vecs[6]  = '{64'h0000000000000003, 64'h00000000000000FB, 1'b1, -15};
        vecs[7]  = '{64'h0000000000000003, 64'h00000000000000FB, 1'b0, 753};
        vecs[8]  = '{64'h0000000000000000, 64'h0000000000000000, 1'b1, 0};
        vecs[9]  = '{64'h0202020202020202, 64'h8181818181818181, 1'b1, -2032};
        vecs[10] = '{64'h0202020202020202, 64'h8181818181818181, 1'b0, 2064};
        vecs[11] = '{64'h0706050403020100, 64'h01FF01FF01FF01FF, 1'b1, 4};

        rst_n = 1'b0; in_valid = 1'b0; is_signed = 1'b0; acc_first = 1'b0; acc_last = 1'b0;
        in_data = '0; in_para = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", m_out_valid, 0);
        check("rst_out_result", m_out_result, 0);
        check("rst_out_ovf", m_out_ovf, 0);
        check("rst_in_ready", m_in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            send(vecs[i].data, vecs[i].para, vecs[i].sg, 1'b1, 1'b1);
            get($sformatf("vec%0d", i), rm, rs, rw, om, os, ow, lat);
            check($sformatf("vec%0d_result", i), rm, vecs[i].exp);
            check($sformatf("vec%0d_ovf", i), om, 0);
            check($sformatf("vec%0d_result20", i), rs, vecs[i].exp);
            if (i == 0) check("latency", lat, 2);
        end

        hs0 = hs;
        for (int b = 0; b < 4; b++) send(64'h3, 64'hFB, 1'b1, b == 0, b == 3);
        get("acc4", rm, rs, rw, om, os, ow, lat);
        check("acc4_result", rm, -60);
        repeat (4) @(negedge clk);
        check("acc4_single_output", hs - hs0, 1);
        send(64'h3, 64'hFB, 1'b1, 1'b0, 1'b1);
        get("nofirst", rm, rs, rw, om, os, ow, lat);
        check("nofirst_result", rm, -15);

        for (int b = 0; b < 5; b++) send(64'h7F7F7F7F7F7F7F7F, 64'h8080808080808080, 1'b0, b == 0, b == 4);
        get("ovf_pos", rm, rs, rw, om, os, ow, lat);
        check("ovfp_main", rm, 650240);
        check("ovfp_main_ovf", om, 0);
        check("ovfp_sat", rs, 524287);
        check("ovfp_sat_ovf", os, 1);
        check("ovfp_wrap", rw, -398336);
        check("ovfp_wrap_ovf", ow, 1);
        for (int b = 0; b < 5; b++) send(64'h8080808080808080, 64'h7F7F7F7F7F7F7F7F, 1'b1, b == 0, b == 4);
        get("ovf_neg", rm, rs, rw, om, os, ow, lat);
        check("ovfn_main", rm, -650240);
        check("ovfn_sat", rs, -524288);
        check("ovfn_sat_ovf", os, 1);
        check("ovfn_wrap", rw, 398336);
        check("ovfn_wrap_ovf", ow, 1);
        send(vecs[3].data, vecs[3].para, 1'b1, 1'b1, 1'b1);
        get("sticky_clr", rm, rs, rw, om, os, ow, lat);
        check("sticky_clr_sat", rs, 28);
        check("sticky_clr_sat_ovf", os, 0);
        check("sticky_clr_wrap_ovf", ow, 0);

        out_ready = 1'b0;
        send(vecs[3].data, vecs[3].para, 1'b1, 1'b1, 1'b1);
        send(vecs[0].data, vecs[0].para, 1'b1, 1'b1, 1'b1);
        send(vecs[2].data, vecs[2].para, 1'b1, 1'b1, 1'b1);
        in_data = vecs[4].data; in_para = vecs[4].para; is_signed = 1'b1;
        acc_first = 1'b1; acc_last = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall%0d_in_ready", k), m_in_ready, 0);
            check($sformatf("stall%0d_out_valid", k), m_out_valid, 1);
            check($sformatf("stall%0d_result", k), $signed(m_out_result), 28);
            @(negedge clk);
        end
        out_ready = 1'b1;
        get("stall_a", rm, rs, rw, om, os, ow, lat);
        in_valid = 1'b0;
        check("stall_a_result", rm, 28);
        get("stall_b", rm, rs, rw, om, os, ow, lat);
        check("stall_b_result", rm, 131072);
        get("stall_c", rm, rs, rw, om, os, ow, lat);
        check("stall_c_result", rm, 8);
        get("stall_d", rm, rs, rw, om, os, ow, lat);
        check("stall_d_result", rm, -130048);

        out_ready = 1'b0;
        send(vecs[0].data, vecs[0].para, 1'b1, 1'b1, 1'b1);
        send(64'h3, 64'hFB, 1'b1, 1'b1, 1'b0);
        send(64'h3, 64'hFB, 1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("prerst_out_valid", m_out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", m_out_valid, 0);
        check("midrst_out_result", m_out_result, 0);
        check("midrst_out_ovf", m_out_ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(64'h3, 64'hFB, 1'b1, 1'b1, 1'b1);
        get("postrst", rm, rs, rw, om, os, ow, lat);
        check("postrst_result", rm, -15);
        check("postrst_ovf", om, 0);
        repeat (4) @(negedge clk);
        check("postrst_idle", m_out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
